// File: rtl/dp_sequencer.sv
// dp_sequencer: multi-cycle fetch/decode/execute/memory/writeback control for the 16-bit datapath.
// Define SEQ_PERF_EN to add the saturating retired / stall_cycles performance counters.
module dp_sequencer #(
   parameter int N   = 16,
   parameter int OPW = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   output logic         imem_req,
   input  logic         imem_ready,
   input  logic [N-1:0] imem_rdata,
   output logic         dmem_req,
   output logic         dmem_we,
   input  logic         dmem_ready,
   input  logic         zero,
   output logic [N-1:0] instr,
   output logic         memtoreg,
   output logic         alusrc,
   output logic         regdst,
   output logic         jump,
   output logic         pcsrc,
   output logic [2:0]   alucontrol,
   output logic         regwrite,
   output logic         pc_en,
   output logic         busy,
   output logic         halted,
`ifdef SEQ_PERF_EN
   output logic         illegal,
   output logic [15:0]  retired,
   output logic [15:0]  stall_cycles
`else
   output logic         illegal
`endif
);
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [OPW-1:0] OP_R    = OPW'(0);
   localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
   localparam logic [OPW-1:0] OP_LW   = OPW'(2);
   localparam logic [OPW-1:0] OP_SW   = OPW'(3);
   localparam logic [OPW-1:0] OP_BEQ  = OPW'(4);
   localparam logic [OPW-1:0] OP_J    = OPW'(5);
   localparam logic [OPW-1:0] OP_HALT = {OPW{1'b1}};

   state_t         state_reg;
   logic           pc_pulse_reg;
   logic [OPW-1:0] op;
   logic           is_r, is_addi, is_lw, is_sw, is_beq, is_j, is_halt, is_bad;

   assign op      = instr[N-1 -: OPW];
   assign is_r    = (op == OP_R);
   assign is_addi = (op == OP_ADDI);
   assign is_lw   = (op == OP_LW);
   assign is_sw   = (op == OP_SW);
   assign is_beq  = (op == OP_BEQ);
   assign is_j    = (op == OP_J);
   assign is_halt = (op == OP_HALT);
   assign is_bad  = !(is_r || is_addi || is_lw || is_sw || is_beq || is_j || is_halt) ||
                    (is_r && (instr[2:0] inside {3'b011, 3'b100, 3'b101}));

   // A store commits in the very cycle its data access completes, so that strobe cannot be registered.
   assign pc_en = pc_pulse_reg || ((state_reg == S_MEM) && is_sw && dmem_ready);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= S_IDLE;
         instr        <= '0;
         imem_req     <= 1'b0;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         memtoreg     <= 1'b0;
         alusrc       <= 1'b0;
         regdst       <= 1'b0;
         jump         <= 1'b0;
         pcsrc        <= 1'b0;
         alucontrol   <= 3'b000;
         regwrite     <= 1'b0;
         pc_pulse_reg <= 1'b0;
         busy         <= 1'b0;
         halted       <= 1'b0;
         illegal      <= 1'b0;
      end else begin
         regwrite     <= 1'b0;
         pc_pulse_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  state_reg <= S_FETCH;
                  imem_req  <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            S_FETCH: begin
               if (imem_ready) begin
                  instr     <= imem_rdata;
                  imem_req  <= 1'b0;
                  state_reg <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (is_bad || is_halt) begin
                  state_reg <= S_HALT;
                  busy      <= 1'b0;
                  halted    <= 1'b1;
                  illegal   <= illegal || is_bad;
               end else begin
                  state_reg  <= S_EXEC;
                  regdst     <= is_r;
                  alusrc     <= is_addi || is_lw || is_sw;
                  memtoreg   <= is_lw;
                  jump       <= is_j;
                  alucontrol <= is_r ? instr[2:0] : (is_beq ? 3'b110 : (is_j ? 3'b000 : 3'b010));
               end
            end
            S_EXEC: begin
               if (is_lw || is_sw) begin
                  state_reg <= S_MEM;
                  dmem_req  <= 1'b1;
                  dmem_we   <= is_sw;
               end else begin
                  // Branch/jump commit one cycle later so pcsrc (zero sampled here) and pc_en arrive together.
                  state_reg    <= S_WB;
                  regwrite     <= is_r || is_addi;
                  pc_pulse_reg <= 1'b1;
                  pcsrc        <= is_beq && zero;
               end
            end
            S_MEM: begin
               if (dmem_ready) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  if (is_lw) begin
                     state_reg    <= S_WB;
                     regwrite     <= 1'b1;
                     pc_pulse_reg <= 1'b1;
                  end else begin
                     state_reg  <= S_FETCH;
                     imem_req   <= 1'b1;
                     memtoreg   <= 1'b0;
                     alusrc     <= 1'b0;
                     regdst     <= 1'b0;
                     jump       <= 1'b0;
                     pcsrc      <= 1'b0;
                     alucontrol <= 3'b000;
                  end
               end
            end
            S_WB: begin
               state_reg  <= S_FETCH;
               imem_req   <= 1'b1;
               memtoreg   <= 1'b0;
               alusrc     <= 1'b0;
               regdst     <= 1'b0;
               jump       <= 1'b0;
               pcsrc      <= 1'b0;
               alucontrol <= 3'b000;
            end
            S_HALT: begin
               state_reg <= S_HALT;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

`ifdef SEQ_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         retired      <= '0;
         stall_cycles <= '0;
      end else begin
         if (pc_en && (retired != 16'hFFFF))
            retired <= retired + 16'd1;
         if (((imem_req && !imem_ready) || (dmem_req && !dmem_ready)) && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer: per-instruction timeline model plus randomized waits and stray inputs.
module tb_dp_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0, zero = 1'b0;
   logic [15:0] imem_rdata = 16'h0000;
   logic        imem_req, dmem_req, dmem_we, memtoreg, alusrc, regdst, jump, pcsrc;
   logic        regwrite, pc_en, busy, halted, illegal;
   logic [2:0]  alucontrol;
   logic [15:0] instr;
`ifdef SEQ_PERF_EN
   logic [15:0] retired, stall_cycles;
`endif

   dp_sequencer #(.N(16), .OPW(4)) dut (
      .clk(clk), .reset(reset), .start(start),
      .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready), .zero(zero),
      .instr(instr), .memtoreg(memtoreg), .alusrc(alusrc), .regdst(regdst), .jump(jump),
      .pcsrc(pcsrc), .alucontrol(alucontrol), .regwrite(regwrite), .pc_en(pc_en),
      .busy(busy), .halted(halted),
`ifdef SEQ_PERF_EN
      .illegal(illegal), .retired(retired), .stall_cycles(stall_cycles)
`else
      .illegal(illegal)
`endif
   );

   always #5 clk = ~clk;

   typedef enum int {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_J, K_HALT, K_BAD} kind_t;

   typedef struct packed {
      logic        imem_req, dmem_req, dmem_we, memtoreg, alusrc, regdst, jump, pcsrc;
      logic [2:0]  alucontrol;
      logic        regwrite, pc_en, busy, halted, illegal;
      logic [15:0] instr, retired, stall;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int          tests = 0, fails = 0;
   logic [15:0] cur_instr = 16'h0000;
   logic        cur_ill = 1'b0;
   logic [15:0] exp_retired = 16'h0000, exp_stall = 16'h0000;

   // statistics measured from the DUT, used by the hand-computed checks
   int   cyc_n = 0, fetch_start = 0, last_lat = 0, pc_pulses = 0, wr_pulses = 0;
   int   dreq_cycles = 0, we_cycles = 0;
   logic prev_ireq = 1'b0, last_pcsrc = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc_n, act, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc_n++;
      if (imem_req && !prev_ireq) fetch_start = cyc_n;
      prev_ireq = imem_req;
      if (pc_en) begin
         last_lat   = cyc_n - fetch_start + 1;
         last_pcsrc = pcsrc;
         pc_pulses++;
      end
      if (regwrite) wr_pulses++;
      if (dmem_req) dreq_cycles++;
      if (dmem_we) we_cycles++;
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         chk("imem_req",   32'(imem_req),   32'(mon_e.imem_req));
         chk("dmem_req",   32'(dmem_req),   32'(mon_e.dmem_req));
         chk("dmem_we",    32'(dmem_we),    32'(mon_e.dmem_we));
         chk("memtoreg",   32'(memtoreg),   32'(mon_e.memtoreg));
         chk("alusrc",     32'(alusrc),     32'(mon_e.alusrc));
         chk("regdst",     32'(regdst),     32'(mon_e.regdst));
         chk("jump",       32'(jump),       32'(mon_e.jump));
         chk("pcsrc",      32'(pcsrc),      32'(mon_e.pcsrc));
         chk("alucontrol", 32'(alucontrol), 32'(mon_e.alucontrol));
         chk("regwrite",   32'(regwrite),   32'(mon_e.regwrite));
         chk("pc_en",      32'(pc_en),      32'(mon_e.pc_en));
         chk("busy",       32'(busy),       32'(mon_e.busy));
         chk("halted",     32'(halted),     32'(mon_e.halted));
         chk("illegal",    32'(illegal),    32'(mon_e.illegal));
         chk("instr",      32'(instr),      32'(mon_e.instr));
`ifdef SEQ_PERF_EN
         chk("retired",      32'(retired),      32'(mon_e.retired));
         chk("stall_cycles", 32'(stall_cycles), 32'(mon_e.stall));
`endif
      end
   end

   function automatic kind_t classify(input logic [15:0] ins);
      logic [3:0] op;
      logic [2:0] f;
      op = ins[15:12];
      f  = ins[2:0];
      case (op)
         4'h0:    return (f == 3'd3 || f == 3'd4 || f == 3'd5) ? K_BAD : K_R;
         4'h1:    return K_ADDI;
         4'h2:    return K_LW;
         4'h3:    return K_SW;
         4'h4:    return K_BEQ;
         4'h5:    return K_J;
         4'hF:    return K_HALT;
         default: return K_BAD;
      endcase
   endfunction

   function automatic exp_t idle_rec();
      exp_t e;
      e = '0;
      e.instr   = cur_instr;
      e.illegal = cur_ill;
      e.retired = exp_retired;
      e.stall   = exp_stall;
      return e;
   endfunction

   function automatic exp_t base();
      exp_t e;
      e = idle_rec();
      e.busy = 1'b1;
      return e;
   endfunction

   // control lines the datapath must see while an instruction is in EXEC/MEM/WB
   function automatic exp_t ctrl(input kind_t k, input logic [15:0] ins);
      exp_t e;
      e = base();
      case (k)
         K_R:     begin e.regdst = 1'b1; e.alucontrol = ins[2:0]; end
         K_ADDI:  begin e.alusrc = 1'b1; e.alucontrol = 3'b010; end
         K_LW:    begin e.alusrc = 1'b1; e.alucontrol = 3'b010; e.memtoreg = 1'b1; end
         K_SW:    begin e.alusrc = 1'b1; e.alucontrol = 3'b010; end
         K_BEQ:   e.alucontrol = 3'b110;
         K_J:     e.jump = 1'b1;
         default: ;
      endcase
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      start      = 1'($urandom);
      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      zero       = 1'($urandom);
      imem_rdata = 16'($urandom);
   endtask

   task automatic clr_stats();
      pc_pulses = 0; wr_pulses = 0; dreq_cycles = 0; we_cycles = 0; last_lat = 0;
   endtask

   task automatic do_reset();
      tick(); reset = 1'b0;
      cur_instr = 16'h0000; cur_ill = 1'b0; exp_retired = 16'h0000; exp_stall = 16'h0000;
      q.push_back(idle_rec());
      tick(); q.push_back(idle_rec());
      tick(); reset = 1'b1; start = 1'b0; q.push_back(idle_rec());
   endtask

   task automatic go();
      tick(); start = 1'b1; q.push_back(idle_rec());
   endtask

   task automatic halt_cycles(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         tick();
         e = idle_rec();
         e.halted = 1'b1;
         q.push_back(e);
      end
   endtask

   // abort >= 0: assert reset in that MEM cycle, then feed a late dmem_ready
   task automatic run_instr(input logic [15:0] ins, input int fw, input int dw, input logic z, input int abort);
      exp_t  e;
      kind_t k;
      k = classify(ins);
      $display("[TB] instr %h kind %s fetch_wait %0d mem_wait %0d zero %0d", ins, k.name(), fw, dw, z);
      for (int i = 0; i <= fw; i++) begin
         tick();
         imem_ready = (i == fw);
         if (i == fw) imem_rdata = ins;
         e = base(); e.imem_req = 1'b1; q.push_back(e);
         if (i < fw) exp_stall++;
      end
      cur_instr = ins;
      tick(); q.push_back(base());
      if (k == K_HALT || k == K_BAD) begin
         cur_ill = cur_ill | (k == K_BAD);
         return;
      end
      tick(); zero = z; q.push_back(ctrl(k, ins));
      if (k == K_LW || k == K_SW) begin
         for (int i = 0; i <= dw; i++) begin
            tick();
            dmem_ready = (i == dw);
            if (i == abort) begin
               reset = 1'b0; dmem_ready = 1'b0;
               cur_instr = 16'h0000; cur_ill = 1'b0; exp_retired = 16'h0000; exp_stall = 16'h0000;
               q.push_back(idle_rec());
               tick(); dmem_ready = 1'b1; q.push_back(idle_rec());
               tick(); reset = 1'b1; start = 1'b0; dmem_ready = 1'b1; q.push_back(idle_rec());
               tick(); start = 1'b0; dmem_ready = 1'b1; q.push_back(idle_rec());
               return;
            end
            e = ctrl(k, ins);
            e.dmem_req = 1'b1;
            e.dmem_we  = (k == K_SW);
            e.pc_en    = (k == K_SW) && (i == dw);
            q.push_back(e);
            if (i < dw) exp_stall++;
            if (e.pc_en) exp_retired++;
         end
         if (k == K_LW) begin
            tick();
            e = ctrl(k, ins); e.regwrite = 1'b1; e.pc_en = 1'b1;
            q.push_back(e);
            exp_retired++;
         end
      end else begin
         tick();
         e = ctrl(k, ins);
         e.pc_en    = 1'b1;
         e.regwrite = (k == K_R) || (k == K_ADDI);
         e.pcsrc    = (k == K_BEQ) && z;
         q.push_back(e);
         exp_retired++;
      end
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [15:0] make_ins(input int k);
      logic [15:0] r;
      logic [2:0]  okf [5];
      okf = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
      r = 16'($urandom);
      r[15:12] = 4'(k);
      if (k == 0) r[2:0] = okf[$urandom_range(0, 4)];
      return r;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      logic [15:0] ins;
      int          k;
      #2 reset = 1'b0;
      do_reset();
      go();

      clr_stats(); run_instr(16'h2123, 0, 3, 1'b0, -1); settle();
      chk("lw_latency", 32'(last_lat), 32'd8);
      chk("lw_dmem_req_cycles", 32'(dreq_cycles), 32'd4);
      chk("lw_dmem_we_cycles", 32'(we_cycles), 32'd0);
      chk("lw_regwrite_pulses", 32'(wr_pulses), 32'd1);

      clr_stats(); run_instr(16'h0012, 0, 0, 1'b0, -1); settle();
      chk("r_latency", 32'(last_lat), 32'd4);
      chk("r_pc_pulses", 32'(pc_pulses), 32'd1);
      chk("r_regwrite_pulses", 32'(wr_pulses), 32'd1);
`ifdef SEQ_PERF_EN
      chk("perf_retired_after_lw", 32'(retired), 32'd1);
      chk("perf_stall_after_lw", 32'(stall_cycles), 32'd3);
`endif

      clr_stats(); run_instr(16'h4000, 0, 0, 1'b1, -1); settle();
      chk("beq1_latency", 32'(last_lat), 32'd4);
      chk("beq1_pcsrc", 32'(last_pcsrc), 32'd1);
      chk("beq1_regwrite_pulses", 32'(wr_pulses), 32'd0);
      clr_stats(); run_instr(16'h4000, 0, 0, 1'b0, -1); settle();
      chk("beq0_pcsrc", 32'(last_pcsrc), 32'd0);
      chk("beq0_pc_pulses", 32'(pc_pulses), 32'd1);

      clr_stats(); run_instr(16'h3045, 0, 2, 1'b0, -1); settle();
      chk("sw_latency", 32'(last_lat), 32'd6);
      chk("sw_dmem_we_cycles", 32'(we_cycles), 32'd3);
      chk("sw_regwrite_pulses", 32'(wr_pulses), 32'd0);

      clr_stats(); run_instr(16'h5ABC, 1, 0, 1'b0, -1); settle();
      chk("j_latency", 32'(last_lat), 32'd5);

      run_instr(16'h7000, 0, 0, 1'b0, -1);
      halt_cycles(4); settle();
      chk("halt_live_halted", 32'(halted), 32'd1);
      chk("halt_live_busy", 32'(busy), 32'd0);
      chk("halt_live_illegal", 32'(illegal), 32'd1);

      do_reset(); go();
      clr_stats(); run_instr(16'h2123, 0, 3, 1'b0, 1); settle();
      chk("abort_regwrite_pulses", 32'(wr_pulses), 32'd0);
      chk("abort_dmem_req_cycles", 32'(dreq_cycles), 32'd1);

      go();
      for (int n = 0; n < 60; n++) begin
         k   = $urandom_range(0, 5);
         ins = make_ins(k);
         run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), -1);
      end
      run_instr(16'hF000, 0, 0, 1'b0, -1);
      halt_cycles(3);

      do_reset(); go();
      run_instr(16'h0003, 2, 0, 1'b0, -1);
      halt_cycles(3);
      do_reset();
      settle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
